alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Sequential initiator that feeds the combinational alu: accepts tagged operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time onto the alu input pins, waits a programmable settle time, then captures out/over/under.
- Returns each result with its tag over a valid/ready response interface and keeps a saturating count of flagged results.
- Sits between a command source (sequencer, host or bench) and the alu instance.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of two, minimum 2.
- TAG_W, 4: width of the command/response tag.
- SETTLE_CYCLES, 1: cycles the alu inputs are held before capture; minimum 1.
- COUNT_W, 16: width of the flagged-result counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_sel  input  4  operation code, encoded as in opcodes.vh.
- cmd_a  input  32  operand A.
- cmd_b  input  32  operand B.
- cmd_tag  input  TAG_W  returned unchanged with the result.
- alu_input1  output  32  to alu input1.
- alu_input2  output  32  to alu input2.
- alu_sel  output  4  to alu alu_sel.
- alu_out  input  32  from alu out.
- alu_over  input  1  from alu over.
- alu_under  input  1  from alu under.
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  32  captured alu_out.
- rsp_over  output  1  captured alu_over.
- rsp_under  output  1  captured alu_under.
- rsp_tag  output  TAG_W  tag of this result.
- busy  output  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- clr_stats  input  1  synchronous clear of flag_count.
- flag_count  output  COUNT_W  count of captures with over or under set; saturates.

Behaviour:
- Reset: when rst_n is low at a clock edge, every output goes to 0 (cmd_ready is 0 during reset and 1 on the first cycle after it).
  - The FIFO is flushed and the FSM returns to IDLE.
  - Any in-flight command and any pending response are discarded without handshake.
- Push: a push occurs when cmd_valid and cmd_ready are both high at an edge.
  - cmd_ready equals "FIFO not full"; it is registered-state only and has no combinational path from cmd_valid or rsp_ready.
  - A same-cycle push and pop on a non-full FIFO is legal and leaves the count unchanged.
  - The FIFO is strict first-in, first-out.
- FSM IDLE: if the FIFO is non-empty, pop the head at this edge, load alu_input1/alu_input2/alu_sel from it, latch its tag, clear the settle counter and go to WAIT.
  - The FIFO is sampled before this edge's push, so there is no bypass.
- FSM WAIT: the alu inputs are held constant.
  - After SETTLE_CYCLES edges in WAIT, capture alu_out/over/under into the rsp_* registers, set rsp_valid and go to RESP.
- FSM RESP: rsp_* are held stable while rsp_valid is high and rsp_ready is low.
  - On the edge where rsp_ready is high, clear rsp_valid and go to IDLE.
  - The next pop happens on the following edge at the earliest.
- The alu_* outputs keep their last issued values when idle; they are never forced back to 0 except by reset.
- Latency: a command pushed into an empty, idle block at edge N is popped at edge N+1. rsp_valid rises after edge N+1+SETTLE_CYCLES (3 edges with the default).
  - Maximum throughput is one result per 2+SETTLE_CYCLES cycles.
- Opcodes: no decoding; any 4-bit cmd_sel value, including an unused code, is passed through to the alu and its outputs are returned as-is.
- flag_count: increments at the capture edge when alu_over or alu_under is high.
  - It holds at all-ones and does not wrap.
  - clr_stats sets it to 0; clr_stats wins over a same-edge increment.
- busy is a registered-state decode with no combinational inputs.

Test Plan:
- Push `ADD, A=0x00000001, B=0x00000002, tag=3 with rsp_ready=1 -> rsp_valid rises 3 edges after the push; rsp_data=0x00000003, rsp_over=0, rsp_under=0, rsp_tag=3; flag_count=0.
- Push `ADD, A=0x7FFFFFFF, B=0x00000001, then `SUB, A=0x80000000, B=0x7FFFFFFF -> first result 0x80000000 with over=1; second has under=1 (per alu flag definition); flag_count=2; pulsing clr_stats gives 0.
- Hold rsp_ready=0 and push 5 commands (tags 0-4) -> one command is in flight; the FIFO then fills with CMD_DEPTH entries and cmd_ready drops; rsp_* stay stable. Release rsp_ready -> tags appear in order 0,1,2,3,4.
- Push `MUL, A=3, B=7 with SETTLE_CYCLES=3 -> alu_* are stable for 3 cycles; rsp_data=21 on the 5th edge after the push.
- Deassert rst_n for one edge while in WAIT with 2 entries queued -> all outputs are 0, no response is ever produced for those commands, busy=0, cmd_ready=1 on the next cycle.
- With COUNT_W=2, issue 5 overflowing `ADD commands -> flag_count reads 1,2,3,3,3; assert clr_stats on the same edge as a capture -> 0.

Source files
------------

// File: rtl/alu_cmd_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver_if
// Brief    : Command and response valid/ready bundle for alu_cmd_driver.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_cmd_driver_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_sel;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_over;
    logic             rsp_under;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_over, rsp_under, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_over, rsp_under, rsp_tag
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver
// Brief    : Queues tagged alu commands, issues them one at a time, waits a
//            settle time and returns the captured result with its tag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
    parameter int CMD_DEPTH     = 4,
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_driver_if.slave    cmd_if,
    output logic [31:0]        alu_input1,
    output logic [31:0]        alu_input2,
    output logic [3:0]         alu_sel,
    input  logic [31:0]        alu_out,
    input  logic               alu_over,
    input  logic               alu_under,
    output logic               busy,
    input  logic               clr_stats,
    output logic [COUNT_W-1:0] flag_count
);
    localparam int c_PTR_W    = $clog2(CMD_DEPTH);
    localparam int c_CNT_W    = c_PTR_W + 1;
    localparam int c_ENTRY_W  = 4 + 32 + 32 + TAG_W;
    localparam int c_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0]    c_FULL        = c_CNT_W'(CMD_DEPTH);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0]    c_COUNT_MAX   = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [c_ENTRY_W-1:0]  r_fifo [CMD_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_CNT_W-1:0]    w_count_next;
    logic                  r_cmd_ready;
    logic [c_ENTRY_W-1:0]  w_head;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_rsp_done;

    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [31:0]           r_alu_in1;
    logic [31:0]           r_alu_in2;
    logic [3:0]            r_alu_sel;
    logic [TAG_W-1:0]      r_cur_tag;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_data;
    logic                  r_rsp_over;
    logic                  r_rsp_under;
    logic [TAG_W-1:0]      r_rsp_tag;
    logic [COUNT_W-1:0]    r_flag_count;

    assign w_push = cmd_if.cmd_valid && r_cmd_ready;
    assign w_head = r_fifo[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage is not reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {cmd_if.cmd_sel, cmd_if.cmd_a, cmd_if.cmd_b, cmd_if.cmd_tag};
        end
    end

    // cmd_ready is registered from the next occupancy so it never depends
    // combinationally on cmd_valid or rsp_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_cmd_ready <= (w_count_next != c_FULL);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (cmd_if.rsp_ready) begin
                    w_rsp_done   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_alu_sel    <= '0;
            r_cur_tag    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_over   <= 1'b0;
            r_rsp_under  <= 1'b0;
            r_rsp_tag    <= '0;
            r_flag_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                {r_alu_sel, r_alu_in1, r_alu_in2, r_cur_tag} <= w_head;
                r_settle_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_settle_cnt <= r_settle_cnt + c_SETTLE_W'(1);
            end
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= alu_out;
                r_rsp_over  <= alu_over;
                r_rsp_under <= alu_under;
                r_rsp_tag   <= r_cur_tag;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
            // A clear on the same edge as a flagged capture takes priority.
            if (clr_stats) begin
                r_flag_count <= '0;
            end else if (w_capture && (alu_over || alu_under) && (r_flag_count != c_COUNT_MAX)) begin
                r_flag_count <= r_flag_count + COUNT_W'(1);
            end
        end
    end

    assign cmd_if.cmd_ready = r_cmd_ready;
    assign cmd_if.rsp_valid = r_rsp_valid;
    assign cmd_if.rsp_data  = r_rsp_data;
    assign cmd_if.rsp_over  = r_rsp_over;
    assign cmd_if.rsp_under = r_rsp_under;
    assign cmd_if.rsp_tag   = r_rsp_tag;
    assign alu_input1       = r_alu_in1;
    assign alu_input2       = r_alu_in2;
    assign alu_sel          = r_alu_sel;
    assign flag_count       = r_flag_count;
    assign busy             = (r_count != '0) || (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_driver
// Brief    : Self-checking bench: default instance plus a SETTLE_CYCLES=3,
//            COUNT_W=2 instance, each driving a behavioural alu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;
    localparam int PERIOD = 10;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2,
                           OP_AND = 4'd3, OP_OR = 4'd4, OP_XOR = 4'd5;
    localparam longint c_MAX = 2147483647;
    localparam longint c_MIN = -c_MAX - 1;

    typedef struct packed {
        logic [31:0] d;
        logic        o;
        logic        u;
        logic [3:0]  t;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr1 = 1'b0;
    logic clr3 = 1'b0;
    int   errors = 0;
    int   checks = 0;
    rsp_t q1[$];
    rsp_t q3[$];

    always #(PERIOD/2) clk = ~clk;

    alu_cmd_driver_if #(.TAG_W(4)) if1 ();
    alu_cmd_driver_if #(.TAG_W(4)) if3 ();

    logic [31:0] a1_in1, a1_in2, a1_out, a3_in1, a3_in2, a3_out;
    logic [3:0]  a1_sel, a3_sel;
    logic        a1_over, a1_under, a3_over, a3_under, busy1, busy3;
    logic [15:0] fc1;
    logic [1:0]  fc3;

    // Behavioural alu: signed result range defines over/under, unused codes yield 0.
    function automatic logic [33:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (s)
            OP_ADD:  r = sa + sb;
            OP_SUB:  r = sa - sb;
            OP_MUL:  r = sa * sb;
            OP_AND:  r = longint'($signed(a & b));
            OP_OR:   r = longint'($signed(a | b));
            OP_XOR:  r = longint'($signed(a ^ b));
            default: r = 0;
        endcase
        return {r > c_MAX, r < c_MIN, r[31:0]};
    endfunction

    assign {a1_over, a1_under, a1_out} = alu_f(a1_sel, a1_in1, a1_in2);
    assign {a3_over, a3_under, a3_out} = alu_f(a3_sel, a3_in1, a3_in2);

    alu_cmd_driver u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_if(if1),
        .alu_input1(a1_in1), .alu_input2(a1_in2), .alu_sel(a1_sel),
        .alu_out(a1_out), .alu_over(a1_over), .alu_under(a1_under),
        .busy(busy1), .clr_stats(clr1), .flag_count(fc1)
    );

    alu_cmd_driver #(.CMD_DEPTH(4), .TAG_W(4), .SETTLE_CYCLES(3), .COUNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_if(if3),
        .alu_input1(a3_in1), .alu_input2(a3_in2), .alu_sel(a3_sel),
        .alu_out(a3_out), .alu_over(a3_over), .alu_under(a3_under),
        .busy(busy3), .clr_stats(clr3), .flag_count(fc3)
    );

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    // Drivers start and end just after a falling edge.
    task automatic push(input int d, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n = 0;
        logic [33:0] r;
        while ((((d == 1) ? if1.cmd_ready : if3.cmd_ready) !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL push_timeout: cmd_ready low for %0d cycles, required 1", n);
        end
        r = alu_f(s, a, b);
        if (d == 1) begin
            if1.cmd_valid = 1'b1; if1.cmd_sel = s; if1.cmd_a = a; if1.cmd_b = b; if1.cmd_tag = t;
            q1.push_back({r[31:0], r[33], r[32], t});
        end else begin
            if3.cmd_valid = 1'b1; if3.cmd_sel = s; if3.cmd_a = a; if3.cmd_b = b; if3.cmd_tag = t;
            q3.push_back({r[31:0], r[33], r[32], t});
        end
        @(negedge clk);
        if1.cmd_valid = 1'b0;
        if3.cmd_valid = 1'b0;
    endtask

    task automatic collect(input int d, input int budget, output rsp_t got, output bit ok, output time seen);
        int n = 0;
        ok = 1'b0; got = '0; seen = 0;
        if (d == 1) if1.rsp_ready = 1'b1; else if3.rsp_ready = 1'b1;
        while (!ok && n < budget) begin
            if (d == 1 && if1.rsp_valid === 1'b1) begin
                got = {if1.rsp_data, if1.rsp_over, if1.rsp_under, if1.rsp_tag}; ok = 1'b1; seen = $time;
            end else if (d == 3 && if3.rsp_valid === 1'b1) begin
                got = {if3.rsp_data, if3.rsp_over, if3.rsp_under, if3.rsp_tag}; ok = 1'b1; seen = $time;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({if1.cmd_ready, if1.rsp_valid, busy1, if1.rsp_over, if1.rsp_under, if1.rsp_tag, fc1} !== '0) begin
            errors++; $display("FAIL reset_ctl1: got %h, required 0", {if1.cmd_ready, if1.rsp_valid, busy1, if1.rsp_over, if1.rsp_under, if1.rsp_tag, fc1}); end
        checks++; if ({a1_in1, a1_in2, a1_sel, if1.rsp_data} !== '0) begin
            errors++; $display("FAIL reset_data1: got %h, required 0", {a1_in1, a1_in2, a1_sel, if1.rsp_data}); end
        checks++; if ({if3.cmd_ready, if3.rsp_valid, busy3, a3_in1, a3_sel, if3.rsp_data, fc3} !== '0) begin
            errors++; $display("FAIL reset_all3: got %h, required 0", {if3.cmd_ready, if3.rsp_valid, busy3, a3_in1, a3_sel, if3.rsp_data, fc3}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({if1.cmd_ready, if3.cmd_ready, busy1, busy3} !== 4'b1100) begin
            errors++; $display("FAIL reset_release: got %b, required 1100", {if1.cmd_ready, if3.cmd_ready, busy1, busy3}); end
    endtask

    task automatic test_basic();
        rsp_t e;
        if1.rsp_ready = 1'b1;
        push(1, OP_ADD, 32'h1, 32'h2, 4'd3);
        checks++; if (if1.rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: rsp_valid got %b, required 0", if1.rsp_valid); end
        @(negedge clk);
        checks++; if ({if1.rsp_valid, busy1} !== 2'b01) begin errors++; $display("FAIL basic_lat2: valid/busy got %b, required 01", {if1.rsp_valid, busy1}); end
        @(negedge clk);
        e = q1.pop_front();
        checks++; if ({if1.rsp_valid, if1.rsp_data, if1.rsp_over, if1.rsp_under, if1.rsp_tag} !== {1'b1, e}) begin
            errors++; $display("FAIL basic_rsp: got %h, required %h", {if1.rsp_valid, if1.rsp_data, if1.rsp_over, if1.rsp_under, if1.rsp_tag}, {1'b1, e}); end
        checks++; if (fc1 !== 16'd0) begin errors++; $display("FAIL basic_count: got %0d, required 0", fc1); end
        @(negedge clk);
        checks++; if ({if1.rsp_valid, busy1} !== 2'b00) begin errors++; $display("FAIL basic_done: valid/busy got %b, required 00", {if1.rsp_valid, busy1}); end
    endtask

    task automatic test_flags();
        rsp_t got, e; bit ok; time ts;
        push(1, OP_ADD, 32'h7FFF_FFFF, 32'h1, 4'd5);
        push(1, OP_SUB, 32'h8000_0000, 32'h7FFF_FFFF, 4'd6);
        for (int i = 0; i < 2; i++) begin
            collect(1, 20, got, ok, ts);
            e = q1.pop_front();
            checks++; if (!ok || got !== e) begin errors++; $display("FAIL flags_rsp%0d: got %h ok=%b, required %h", i, got, ok, e); end
        end
        checks++; if (fc1 !== 16'd2) begin errors++; $display("FAIL flags_count: got %0d, required 2", fc1); end
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        checks++; if (fc1 !== 16'd0) begin errors++; $display("FAIL flags_clear: got %0d, required 0", fc1); end
    endtask

    task automatic test_fill();
        rsp_t got, e, snap; bit ok; time t_prev, t_now;
        t_prev = 0;
        if1.rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++) push(1, 4'($urandom_range(0, 5)), $urandom, $urandom, 4'(t));
        checks++; if ({if1.cmd_ready, busy1} !== 2'b01) begin errors++; $display("FAIL fill_full: ready/busy got %b, required 01", {if1.cmd_ready, busy1}); end
        @(negedge clk);
        snap = {if1.rsp_data, if1.rsp_over, if1.rsp_under, if1.rsp_tag};
        checks++; if (if1.rsp_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b, required 1", if1.rsp_valid); end
        repeat (3) begin
            @(negedge clk);
            checks++; if ({if1.rsp_valid, if1.rsp_data, if1.rsp_over, if1.rsp_under, if1.rsp_tag, if1.cmd_ready} !== {1'b1, snap, 1'b0}) begin
                errors++; $display("FAIL fill_hold: got %h, required %h", {if1.rsp_valid, if1.rsp_data, if1.rsp_over, if1.rsp_under, if1.rsp_tag, if1.cmd_ready}, {1'b1, snap, 1'b0}); end
        end
        for (int i = 0; i < 5; i++) begin
            collect(1, 20, got, ok, t_now);
            e = (q1.size() > 0) ? q1.pop_front() : '0;
            checks++; if (!ok || got !== e || got.t !== 4'(i)) begin
                errors++; $display("FAIL fill_order%0d: got %h ok=%b, required %h", i, got, ok, e); end
            if (i > 0) begin
                checks++; if (t_now - t_prev != 3 * PERIOD) begin
                    errors++; $display("FAIL fill_rate%0d: spacing %0t, required %0t", i, t_now - t_prev, 3 * PERIOD); end
            end
            t_prev = t_now;
        end
    endtask

    task automatic test_settle3();
        rsp_t e;
        if3.rsp_ready = 1'b1;
        push(3, OP_MUL, 32'd3, 32'd7, 4'd9);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if ({a3_in1, a3_in2, a3_sel, if3.rsp_valid} !== {32'd3, 32'd7, OP_MUL, 1'b0}) begin
                errors++; $display("FAIL settle_hold%0d: got %h, required %h", k, {a3_in1, a3_in2, a3_sel, if3.rsp_valid}, {32'd3, 32'd7, OP_MUL, 1'b0}); end
        end
        @(negedge clk);
        e = q3.pop_front();
        checks++; if ({if3.rsp_valid, if3.rsp_data, if3.rsp_over, if3.rsp_under, if3.rsp_tag} !== {1'b1, e} || if3.rsp_data !== 32'd21) begin
            errors++; $display("FAIL settle_rsp: got %h, required %h", {if3.rsp_valid, if3.rsp_data, if3.rsp_over, if3.rsp_under, if3.rsp_tag}, {1'b1, e}); end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        bit seen = 1'b0;
        if3.rsp_ready = 1'b0;
        push(3, OP_ADD, 32'd10, 32'd20, 4'd1);
        push(3, OP_SUB, 32'd50, 32'd8, 4'd2);
        push(3, OP_XOR, 32'hF0F0, 32'h0FF0, 4'd3);
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, required 1", busy3); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if ({a3_in1, a3_in2, a3_sel, if3.rsp_data, if3.rsp_valid, if3.rsp_over, if3.rsp_under, if3.rsp_tag, if3.cmd_ready, busy3, fc3} !== '0) begin
            errors++; $display("FAIL mid_zero: got %h, required 0", {a3_in1, a3_in2, a3_sel, if3.rsp_data, if3.rsp_valid, if3.rsp_tag, if3.cmd_ready, busy3, fc3}); end
        q3.delete();
        @(negedge clk);
        checks++; if ({if3.cmd_ready, busy3} !== 2'b10) begin errors++; $display("FAIL mid_release: ready/busy got %b, required 10", {if3.cmd_ready, busy3}); end
        if3.rsp_ready = 1'b1;
        repeat (12) begin
            if (if3.rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_no_rsp: rsp_valid got 1, required 0 throughout"); end
    endtask

    task automatic test_saturate();
        rsp_t got, e; bit ok; time ts;
        for (int i = 0; i < 5; i++) begin
            push(3, OP_ADD, 32'h7FFF_FFF0, 32'h100 + 32'($urandom_range(0, 255)), 4'(i));
            collect(3, 20, got, ok, ts);
            e = q3.pop_front();
            checks++; if (!ok || got !== e) begin errors++; $display("FAIL sat_rsp%0d: got %h ok=%b, required %h", i, got, ok, e); end
            checks++; if (fc3 !== 2'((i < 3) ? i + 1 : 3)) begin
                errors++; $display("FAIL sat_count%0d: got %0d, required %0d", i, fc3, (i < 3) ? i + 1 : 3); end
        end
        push(3, OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd7);
        repeat (3) @(negedge clk);
        checks++; if ({if3.rsp_valid, fc3} !== 3'b011) begin errors++; $display("FAIL sat_pre: valid/count got %b, required 011", {if3.rsp_valid, fc3}); end
        clr3 = 1'b1;
        @(negedge clk);
        clr3 = 1'b0;
        checks++; if ({if3.rsp_valid, fc3} !== 3'b100) begin errors++; $display("FAIL sat_clr_wins: valid/count got %b, required 100", {if3.rsp_valid, fc3}); end
        collect(3, 20, got, ok, ts);
        e = q3.pop_front();
        checks++; if (!ok || got !== e) begin errors++; $display("FAIL sat_last: got %h ok=%b, required %h", got, ok, e); end
    endtask

    task automatic test_random();
        rsp_t cur, held, got, e; bit ok, stalled; time ts;
        logic [33:0] r;
        int sent = 0, exp_fc = 0;
        stalled = 1'b0; held = '0;
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            cur = {if1.rsp_data, if1.rsp_over, if1.rsp_under, if1.rsp_tag};
            if (stalled) begin
                checks++; if (if1.rsp_valid !== 1'b1 || cur !== held) begin
                    errors++; $display("FAIL rand_stall%0d: got %b/%h, required 1/%h", cyc, if1.rsp_valid, cur, held); end
            end
            if1.rsp_ready = ($urandom_range(0, 3) != 0);
            if (sent < 40 && $urandom_range(0, 1) == 1) begin
                if1.cmd_valid = 1'b1; if1.cmd_sel = 4'($urandom_range(0, 15));
                if1.cmd_a = $urandom; if1.cmd_b = $urandom; if1.cmd_tag = 4'(sent);
            end else begin
                if1.cmd_valid = 1'b0;
            end
            if (if1.cmd_valid && if1.cmd_ready === 1'b1) begin
                r = alu_f(if1.cmd_sel, if1.cmd_a, if1.cmd_b);
                q1.push_back({r[31:0], r[33], r[32], if1.cmd_tag});
                sent++;
            end
            if (if1.rsp_valid === 1'b1 && if1.rsp_ready) begin
                e = (q1.size() > 0) ? q1.pop_front() : '0;
                checks++; if (cur !== e) begin errors++; $display("FAIL rand_rsp%0d: got %h, required %h", cyc, cur, e); end
                if (e.o || e.u) exp_fc++;
            end
            stalled = (if1.rsp_valid === 1'b1) && !if1.rsp_ready;
            held = cur;
            @(negedge clk);
        end
        if1.cmd_valid = 1'b0;
        while (q1.size() > 0) begin
            collect(1, 30, got, ok, ts);
            e = q1.pop_front();
            checks++; if (!ok || got !== e) begin errors++; $display("FAIL rand_drain: got %h ok=%b, required %h", got, ok, e); end
            if (e.o || e.u) exp_fc++;
            if (!ok) break;
        end
        checks++; if (fc1 !== 16'(exp_fc)) begin errors++; $display("FAIL rand_count: got %0d, required %0d", fc1, exp_fc); end
    endtask

    initial begin
        if1.cmd_valid = 1'b0; if1.cmd_sel = '0; if1.cmd_a = '0; if1.cmd_b = '0; if1.cmd_tag = '0; if1.rsp_ready = 1'b0;
        if3.cmd_valid = 1'b0; if3.cmd_sel = '0; if3.cmd_a = '0; if3.cmd_b = '0; if3.cmd_tag = '0; if3.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_flags();
        test_fill();
        test_settle3();
        test_reset_midflight();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
